// File: rtl/flip_flop_sr.sv
// Single-bit clocked set/clear storage element with synchronous active-high reset.
// s=r=1 holds the current value, so q is never driven to X.
module flip_flop_sr (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else begin
      case ({s, r})
        2'b10:   r_q <= 1'b1;
        2'b01:   r_q <= 1'b0;
        default: r_q <= r_q;  // 00 and 11 both hold
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_flip_flop_sr.sv
// Directed bench for flip_flop_sr: reset, set/clear/hold, s=r=1, reset priority and
// edge-only sampling, with expected values written out per step.
module tb_flip_flop_sr;

  logic clk;
  logic reset;
  logic s;
  logic r;
  logic q;

  int n_checks;
  int n_errors;

  flip_flop_sr dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .r     (r),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample q just after the next rising edge.
  task automatic step(input logic i_reset, input logic i_s, input logic i_r,
                      input logic exp, input string tag);
    @(negedge clk);
    reset = i_reset;
    s     = i_s;
    r     = i_r;
    @(posedge clk);
    #1;
    check(tag, q, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    s        = 1'b0;
    r        = 1'b0;

    // Reset and post-reset hold
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset_edge1");
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset_edge2");
    step(1'b0, 1'b0, 1'b0, 1'b0, "post_reset_hold1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "post_reset_hold2");

    // Set, hold, idempotent set
    step(1'b0, 1'b1, 1'b0, 1'b1, "set");
    step(1'b0, 1'b0, 1'b0, 1'b1, "hold1_a");
    step(1'b0, 1'b0, 1'b0, 1'b1, "hold1_b");
    step(1'b0, 1'b0, 1'b0, 1'b1, "hold1_c");
    step(1'b0, 1'b1, 1'b0, 1'b1, "set_again");

    // Clear, hold, idempotent clear
    step(1'b0, 1'b0, 1'b1, 1'b0, "clear");
    step(1'b0, 1'b0, 1'b0, 1'b0, "hold0_a");
    step(1'b0, 1'b0, 1'b0, 1'b0, "hold0_b");
    step(1'b0, 1'b0, 1'b0, 1'b0, "hold0_c");
    step(1'b0, 1'b0, 1'b1, 1'b0, "clear_again");

    // Simultaneous s=r=1 holds from both states
    step(1'b0, 1'b1, 1'b1, 1'b0, "sr11_from0");
    step(1'b0, 1'b1, 1'b0, 1'b1, "set_before_sr11");
    step(1'b0, 1'b1, 1'b1, 1'b1, "sr11_from1");

    // Reset overrides a concurrent set; set resumes once reset drops
    step(1'b1, 1'b1, 1'b0, 1'b0, "reset_over_set");
    step(1'b0, 1'b1, 1'b0, 1'b1, "set_after_reset");

    // s pulse entirely between edges from q=0
    step(1'b0, 1'b0, 1'b1, 1'b0, "clear_before_glitch");
    @(negedge clk);
    r = 1'b0;
    #1 s = 1'b1;
    #1 s = 1'b0;
    @(posedge clk);
    #1;
    check("s_glitch_ignored", q, 1'b0);

    // r pulse entirely between edges from q=1
    step(1'b0, 1'b1, 1'b0, 1'b1, "set_before_glitch");
    @(negedge clk);
    s = 1'b0;
    #1 r = 1'b1;
    #1 r = 1'b0;
    @(posedge clk);
    #1;
    check("r_glitch_ignored", q, 1'b1);

    // Reset asserted between edges only takes effect at the next rising edge
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("reset_mid_no_effect", q, 1'b1);
    @(posedge clk);
    #1;
    check("reset_mid_applied", q, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, "hold_after_reset_mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
